chien_par: RTL and testbench

CHIEN_PAR -- requirements
Module: chien_par

---
 rtl/chien_par_pkg.sv | 46 ++++
 rtl/chien_cmul.sv | 28 ++
 rtl/chien_par.sv | 138 +++++++++++++
 tb/tb_chien_par.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chien_par_pkg.sv
// Shared GF(2^M) helpers and state encodings for the parallel Chien search.
package chien_par_pkg;

    localparam int unsigned MAX_M = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Primitive field polynomial for GF(2^m), bit k = coefficient of x^k
    function automatic logic [MAX_M:0] prim_poly(input int unsigned m);
        case (m)
            3:       prim_poly = 17'h0000B;
            4:       prim_poly = 17'h00013;
            5:       prim_poly = 17'h00025;
            6:       prim_poly = 17'h00043;
            7:       prim_poly = 17'h00089;
            8:       prim_poly = 17'h0011D;
            9:       prim_poly = 17'h00211;
            10:      prim_poly = 17'h00409;
            11:      prim_poly = 17'h00805;
            12:      prim_poly = 17'h01053;
            13:      prim_poly = 17'h0201B;
            14:      prim_poly = 17'h04443;
            15:      prim_poly = 17'h08003;
            16:      prim_poly = 17'h1100B;
            default: prim_poly = 17'h00013;
        endcase
    endfunction

    // alpha^e in polynomial basis; exponent reduced modulo the field order
    function automatic logic [MAX_M-1:0] lpow(input int unsigned m, input int unsigned e);
        logic [MAX_M:0] v;
        int unsigned    ord;
        ord = (32'd1 << m) - 32'd1;
        v   = 17'd1;
        for (int unsigned k = 0; k < (e % ord); k++) begin
            v = v << 1;
            if (v[m]) begin
                v = v ^ prim_poly(m);
            end
        end
        return v[MAX_M-1:0];
    endfunction

endpackage

// File: rtl/chien_cmul.sv
// Combinational multiply of a GF(2^M) element by the constant alpha^K.
module chien_cmul
    import chien_par_pkg::*;
#(
    parameter int unsigned M = 4,
    parameter int unsigned K = 0
) (
    input  logic [M-1:0] a_i,
    output logic [M-1:0] y_o
);

    logic [M-1:0] part [M];

    // Column b of the constant matrix is alpha^(K+b)
    for (genvar b = 0; b < M; b++) begin : g_col
        localparam logic [M-1:0] COL = M'(lpow(M, K + b));
        assign part[b] = a_i[b] ? COL : '0;
    end

    // XOR-reduce the selected columns
    always_comb begin
        y_o = '0;
        for (int unsigned b = 0; b < M; b++) begin
            y_o = y_o ^ part[b];
        end
    end

endmodule

// File: rtl/chien_par.sv
// Parallel Chien search: evaluates the error locator at PAR positions per beat.
module chien_par
    import chien_par_pkg::*;
#(
    parameter int unsigned M   = 4,
    parameter int unsigned T   = 3,
    parameter int unsigned N   = (1 << M) - 1,
    parameter int unsigned PAR = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [M*(T+1)-1:0]                    sigma,
    input  logic [((T > 0) ? $clog2(T+1) : 1)-1:0] deg,
    input  logic                                  ce,
    output logic                                  busy,
    output logic                                  valid,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  pos,
    output logic [PAR-1:0]                        err,
    output logic                                  done,
    output logic [$clog2(T+2)-1:0]                err_count,
    output logic                                  fail
);

    localparam int unsigned DW  = (T > 0) ? $clog2(T + 1) : 1;
    localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW  = $clog2(T + 2);
    localparam int unsigned SAT = T + 1;

    logic [1:0]    state_q, state_d;
    logic [M-1:0]  r_q [T+1];
    logic [M-1:0]  r_d [T+1];
    logic [M-1:0]  r_adv [T+1];
    logic [PW-1:0] pos_q, pos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] deg_q, deg_d;
    logic [PAR-1:0] lane_hit;
    logic          last_beat;
    logic [31:0]   pop;
    logic [31:0]   cnt_sum;

    // Per-beat advance: r_i *= alpha^(i*PAR)
    for (genvar i = 0; i <= T; i++) begin : g_adv
        chien_cmul #(.M(M), .K(i * PAR)) u_adv (.a_i(r_q[i]), .y_o(r_adv[i]));
    end

    // Lane j evaluates sigma at alpha^(pos+j); in-range roots are hits
    for (genvar j = 0; j < PAR; j++) begin : g_lane
        logic [M-1:0] term [T+1];
        logic [M-1:0] sum;
        for (genvar i = 0; i <= T; i++) begin : g_term
            chien_cmul #(.M(M), .K(i * j)) u_term (.a_i(r_q[i]), .y_o(term[i]));
        end
        // Sum of the lane's terms
        always_comb begin
            sum = '0;
            for (int unsigned i = 0; i <= T; i++) begin
                sum = sum ^ term[i];
            end
        end
        assign lane_hit[j] = (sum == '0) && ((32'(pos_q) + 32'(j)) < N);
    end

    assign busy      = (state_q != ST_IDLE);
    assign valid     = (state_q == ST_RUN) && ce;
    assign err       = valid ? lane_hit : '0;
    assign pos       = pos_q;
    assign done      = (state_q == ST_DONE);
    assign err_count = cnt_q;
    assign fail      = done && ((32'(cnt_q) != 32'(deg_q)) || ((deg_q == '0) && (cnt_q != '0)));
    assign last_beat = (32'(pos_q) + PAR) >= N;

    // Saturating error count for this beat
    always_comb begin
        pop = '0;
        for (int unsigned j = 0; j < PAR; j++) begin
            pop = pop + 32'(err[j]);
        end
        cnt_sum = 32'(cnt_q) + pop;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        deg_d   = deg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int unsigned i = 0; i <= T; i++) begin
                        r_d[i] = sigma[i*M +: M];
                    end
                    pos_d   = '0;
                    cnt_d   = '0;
                    deg_d   = deg;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ce) begin
                    r_d   = r_adv;
                    cnt_d = (cnt_sum >= SAT) ? CW'(SAT) : CW'(cnt_sum);
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end else begin
                        pos_d = PW'(32'(pos_q) + PAR);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '{default: '0};
            pos_q   <= '0;
            cnt_q   <= '0;
            deg_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            deg_q   <= deg_d;
        end
    end

endmodule

// File: tb/tb_chien_par.sv
// Scoreboard bench for chien_par over GF(16), x^4+x+1, T=2, N=15.
module tb_chien_par;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [11:0] sigma;
    logic [1:0]  deg;
    logic        start4, start1, start15;

    logic        busy4, valid4, done4, fail4;
    logic [3:0]  pos4;
    logic [3:0]  err4;
    logic [1:0]  cnt4;
    logic        busy1, valid1, done1, fail1;
    logic [3:0]  pos1;
    logic [0:0]  err1;
    logic [1:0]  cnt1;
    logic        busy15, valid15, done15, fail15;
    logic [3:0]  pos15;
    logic [14:0] err15;
    logic [1:0]  cnt15;

    typedef struct {
        bit is_done;
        int pos;
        int err;
        int cnt;
        bit fl;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    exp_t q15[$];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    chien_par #(.M(4), .T(2), .N(15), .PAR(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .sigma(sigma), .deg(deg), .ce(ce),
        .busy(busy4), .valid(valid4), .pos(pos4), .err(err4), .done(done4),
        .err_count(cnt4), .fail(fail4));

    chien_par #(.M(4), .T(2), .N(15), .PAR(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .sigma(sigma), .deg(deg), .ce(ce),
        .busy(busy1), .valid(valid1), .pos(pos1), .err(err1), .done(done1),
        .err_count(cnt1), .fail(fail1));

    chien_par #(.M(4), .T(2), .N(15), .PAR(15)) u_dut15 (
        .clk(clk), .rst(rst), .start(start15), .sigma(sigma), .deg(deg), .ce(ce),
        .busy(busy15), .valid(valid15), .pos(pos15), .err(err15), .done(done15),
        .err_count(cnt15), .fail(fail15));

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    task automatic unexpected(input string tag, input int v, input int d);
        total++;
        $display("FAIL %s_unexpected: valid=%0d done=%0d with empty scoreboard", tag, v, d);
    endtask

    task automatic check_evt(input string tag, input exp_t e, input int v, input int d,
                             input int p, input int er, input int c, input int f);
        if (e.is_done) begin
            chk({tag, "_done"}, d, 1);
            chk({tag, "_cnt"}, c, e.cnt);
            chk({tag, "_fail"}, f, int'(e.fl));
        end else begin
            chk({tag, "_valid"}, v, 1);
            chk({tag, "_pos"}, p, e.pos);
            chk({tag, "_err"}, er, e.err);
        end
    endtask

    function automatic exp_t beat(input int p, input int e);
        exp_t x;
        x = '{1'b0, p, e, 0, 1'b0};
        return x;
    endfunction

    function automatic exp_t fin(input int c, input bit f);
        exp_t x;
        x = '{1'b1, 0, 0, c, f};
        return x;
    endfunction

    // Monitors: compare every presented beat / done against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (valid4 || done4) begin
                if (q4.size() == 0) unexpected("p4", int'(valid4), int'(done4));
                else check_evt("p4", q4.pop_front(), int'(valid4), int'(done4),
                               int'(pos4), int'(err4), int'(cnt4), int'(fail4));
            end else begin
                chk("p4_err_quiet", int'(err4), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (valid1 || done1)) begin
            if (q1.size() == 0) unexpected("p1", int'(valid1), int'(done1));
            else check_evt("p1", q1.pop_front(), int'(valid1), int'(done1),
                           int'(pos1), int'(err1), int'(cnt1), int'(fail1));
        end
    end

    always @(negedge clk) begin
        if (!rst && (valid15 || done15)) begin
            if (q15.size() == 0) unexpected("p15", int'(valid15), int'(done15));
            else check_evt("p15", q15.pop_front(), int'(valid15), int'(done15),
                           int'(pos15), int'(err15), int'(cnt15), int'(fail15));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 4 = PAR4 instance, 5 = PAR1 and PAR15 together
    task automatic start_run(input int which, input logic [3:0] s0, input logic [3:0] s1,
                             input logic [3:0] s2, input logic [1:0] d);
        sigma = {s2, s1, s0};
        deg   = d;
        if (which == 4) start4 = 1'b1;
        else begin
            start1  = 1'b1;
            start15 = 1'b1;
        end
        tick();
        start4  = 1'b0;
        start1  = 1'b0;
        start15 = 1'b0;
    endtask

    task automatic wait_done(input int which, input bit toggle, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            ce = toggle ? (k % 3 == 0) : 1'b1;
            if (toggle && k == 4) begin
                start4 = 1'b1;
                sigma  = '0;
            end else begin
                start4 = 1'b0;
            end
            tick();
            seen = (which == 4) ? done4 : done1;
        end
        start4 = 1'b0;
        if (!seen) begin
            total++;
            $display("FAIL timeout_done: no done within %0d cycles, expected done", budget);
        end
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        ce      = 1'b0;
        sigma   = '0;
        deg     = '0;
        start4  = 1'b0;
        start1  = 1'b0;
        start15 = 1'b0;
        repeat (3) tick();
        chk("rst_busy", int'(busy4), 0);
        chk("rst_valid", int'(valid4), 0);
        chk("rst_pos", int'(pos4), 0);
        chk("rst_err", int'(err4), 0);
        chk("rst_done", int'(done4), 0);
        chk("rst_cnt", int'(cnt4), 0);
        chk("rst_fail", int'(fail4), 0);
        rst = 1'b0;
        tick();

        // sigma = 1: no roots
        for (int p = 0; p < 15; p += 4) q4.push_back(beat(p, 0));
        q4.push_back(fin(0, 1'b0));
        start_run(4, 4'h1, 4'h0, 4'h0, 2'd0);
        chk("busy_after_start", int'(busy4), 1);
        wait_done(4, 1'b0, 40);

        // sigma = 1 + alpha^12 x: single root at position 3
        q4.push_back(beat(0, 8));
        for (int p = 4; p < 15; p += 4) q4.push_back(beat(p, 0));
        q4.push_back(fin(1, 1'b0));
        start_run(4, 4'h1, 4'hF, 4'h0, 2'd1);
        wait_done(4, 1'b0, 40);

        // sigma = 0: every position hits, count saturates at 3
        q4.push_back(beat(0, 15));
        q4.push_back(beat(4, 15));
        q4.push_back(beat(8, 15));
        q4.push_back(beat(12, 7));
        q4.push_back(fin(3, 1'b1));
        start_run(4, 4'h0, 4'h0, 4'h0, 2'd2);
        wait_done(4, 1'b0, 40);

        // Single root with stalls and an ignored start mid-run
        q4.push_back(beat(0, 8));
        for (int p = 4; p < 15; p += 4) q4.push_back(beat(p, 0));
        q4.push_back(fin(1, 1'b0));
        start_run(4, 4'h1, 4'hF, 4'h0, 2'd1);
        wait_done(4, 1'b1, 60);

        // Reset during the second beat aborts without a done pulse
        q4.push_back(beat(0, 0));
        start_run(4, 4'h1, 4'h0, 4'h0, 2'd0);
        ce = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", int'(busy4), 0);
        chk("abort_pos", int'(pos4), 0);
        chk("abort_cnt", int'(cnt4), 0);
        rst = 1'b0;
        repeat (6) tick();
        chk("abort_drained", q4.size(), 0);
        for (int p = 0; p < 15; p += 4) q4.push_back(beat(p, 0));
        q4.push_back(fin(0, 1'b0));
        start_run(4, 4'h1, 4'h0, 4'h0, 2'd0);
        wait_done(4, 1'b0, 40);

        // Same single-root locator at PAR=1 and PAR=15
        for (int p = 0; p < 15; p++) q1.push_back(beat(p, (p == 3) ? 1 : 0));
        q1.push_back(fin(1, 1'b0));
        q15.push_back(beat(0, 8));
        q15.push_back(fin(1, 1'b0));
        start_run(5, 4'h1, 4'hF, 4'h0, 2'd1);
        wait_done(1, 1'b0, 60);

        repeat (3) tick();
        chk("q4_empty", q4.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q15_empty", q15.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
